// File: rtl/stopwatch_display_driver_pkg.sv
// Shared definitions for the stopwatch display driver: status codes,
// conversion FSM states, 7-segment patterns and display limits.
// Imported by stopwatch_display_driver and bin2bcd_seq.
package stopwatch_display_driver_pkg;

  // Status encoding from the stopwatch core; 2'b11 behaves like IDLE.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_PAUSE    = 2'b10,
    ST_IDLE_ALT = 2'b11
  } status_t;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_CAPT,
    CS_SHIFT,
    CS_LOAD
  } conv_state_t;

  // Segment patterns {g,f,e,d,c,b,a}, active-low.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [7:0] MIN_DISP_MAX = 8'd99;
  // Saturated minutes never reach 0xFF, so this can never match a live input.
  localparam logic [7:0] CAPT_INVALID = 8'hFF;
  // One double-dabble iteration per input bit.
  localparam logic [3:0] DD_ITERS     = 4'd8;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to two-digit BCD converter (double-dabble).
// Latency: start_i loads, then 8 cycles of shift_i produce the result.
// No backpressure: the controlling FSM owns start/shift sequencing.
// Ports: clk, rst_n; start_i loads bin_i and clears the BCD scratch;
//   shift_i runs one add-3/shift iteration; tens_o/ones_o hold the BCD result;
//   done_o is high during the final iteration, so the next edge completes it.
// Inputs above 99 lose their hundreds digit; callers keep values <= 99.
module bin2bcd_seq
  import stopwatch_display_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       shift_i,
  input  logic [7:0] bin_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       done_o
);

  logic [7:0] bin_q, bin_d;
  logic [7:0] bcd_q, bcd_d;
  logic [3:0] iter_q, iter_d;
  logic [7:0] bcd_adj;

  always_comb begin
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    iter_d  = iter_q;
    bcd_adj = bcd_q;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      iter_d = '0;
    end else if (shift_i && (iter_q < DD_ITERS)) begin
      // Pre-correct any nibble >= 5 so the shift yields a valid BCD carry.
      if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
      if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
      {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
      iter_d = iter_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      iter_q <= iter_d;
    end
  end

  assign tens_o = bcd_q[7:4];
  assign ones_o = bcd_q[3:0];
  assign done_o = shift_i && (iter_q == (DD_ITERS - 4'd1));

endmodule

// File: rtl/stopwatch_display_driver.sv
// MM:SS stopwatch display driver: saturate, BCD-convert and scan four 7-seg digits.
// Latency: input change sampled at edge E is in the digit regs after edge E+10.
// No backpressure: inputs changing mid-conversion are picked up on the next pass.
// Ports: clk, rst_n (async, active-low); minutes[7:0], seconds[5:0], status[1:0]
//   from the stopwatch core; an_n[3:0] digit enables (active-low, [0]=sec ones ..
//   [3]=min tens); seg_n[6:0] segments {g,f,e,d,c,b,a} active-low; busy = converter active.
// Optional feature macro: STOPWATCH_DISP_BLINK_EN blinks the display while PAUSED.
module stopwatch_display_driver
  import stopwatch_display_driver_pkg::*;
#(
  parameter int REFRESH_DIV = 1000,
  parameter int BLINK_DIV   = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] minutes,
  input  logic [5:0] seconds,
  input  logic [1:0] status,
  output logic [3:0] an_n,
  output logic [6:0] seg_n,
  output logic       busy
);

  localparam int PW = $clog2(REFRESH_DIV);

  // ---------------------------------------------------------------
  // Conversion control
  // ---------------------------------------------------------------
  conv_state_t     state_q;
  logic            busy_q;
  logic [7:0]      cap_min_q;
  logic [5:0]      cap_sec_q;
  logic [7:0]      last_min_q;
  logic [5:0]      last_sec_q;
  logic [3:0][3:0] dig_q;       // [0]=sec ones [1]=sec tens [2]=min ones [3]=min tens

  logic [7:0] min_sat;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       min_done, sec_done;
  logic       conv_start, conv_shift;

  assign min_sat    = (minutes > MIN_DISP_MAX) ? MIN_DISP_MAX : minutes;
  assign conv_start = (state_q == CS_CAPT);
  assign conv_shift = (state_q == CS_SHIFT);

  bin2bcd_seq u_min_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .shift_i (conv_shift),
    .bin_i   (min_sat),
    .tens_o  (min_tens),
    .ones_o  (min_ones),
    .done_o  (min_done)
  );

  bin2bcd_seq u_sec_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (conv_start),
    .shift_i (conv_shift),
    .bin_i   ({2'b00, seconds}),
    .tens_o  (sec_tens),
    .ones_o  (sec_ones),
    .done_o  (sec_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CS_IDLE;
      busy_q     <= 1'b0;
      cap_min_q  <= '0;
      cap_sec_q  <= '0;
      last_min_q <= CAPT_INVALID;
      last_sec_q <= '0;
      dig_q      <= '0;
    end else begin
      case (state_q)
        CS_IDLE: begin
          if ({min_sat, seconds} != {last_min_q, last_sec_q}) begin
            state_q <= CS_CAPT;
            busy_q  <= 1'b1;
          end
        end
        CS_CAPT: begin
          // Same cycle the converters latch their inputs, so these match.
          cap_min_q <= min_sat;
          cap_sec_q <= seconds;
          state_q   <= CS_SHIFT;
        end
        CS_SHIFT: begin
          if (min_done && sec_done) state_q <= CS_LOAD;
        end
        CS_LOAD: begin
          dig_q      <= {min_tens, min_ones, sec_tens, sec_ones};
          last_min_q <= cap_min_q;
          last_sec_q <= cap_sec_q;
          busy_q     <= 1'b0;
          state_q    <= CS_IDLE;
        end
        default: begin
          state_q <= CS_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;

  // ---------------------------------------------------------------
  // Digit scan
  // ---------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic          scan_tick;
  logic          frame_tick;
  logic          blank;
  logic [3:0]    an_n_q, an_n_d;
  logic [6:0]    seg_n_q, seg_n_d;

  assign scan_tick  = (presc_q == PW'(REFRESH_DIV - 1));
  assign frame_tick = scan_tick && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      idx_q   <= '0;
    end else begin
      presc_q <= scan_tick ? '0 : presc_q + 1'b1;
      if (scan_tick) idx_q <= idx_q + 2'd1;
    end
  end

`ifdef STOPWATCH_DISP_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV) + 1;

  logic [BW-1:0] blink_cnt_q;
  logic          blink_phase_q;

  // Held cleared outside PAUSED so every pause starts with a full lit half-period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (status != ST_PAUSE) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (frame_tick) begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_q   <= '0;
        blink_phase_q <= ~blink_phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Uses live status so leaving PAUSED relights the digits on the next edge.
  assign blank = (status == ST_PAUSE) && blink_phase_q;
`else
  logic unused_cfg;
  assign unused_cfg = (^status) ^ frame_tick ^ (BLINK_DIV > 0);
  assign blank      = 1'b0;
`endif

  always_comb begin
    an_n_d  = ~(4'b0001 << idx_q);
    seg_n_d = seg_decode(dig_q[idx_q]);
    if (blank) an_n_d = 4'hF;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_n_q  <= 4'hF;
      seg_n_q <= SEG_BLANK;
    end else begin
      an_n_q  <= an_n_d;
      seg_n_q <= seg_n_d;
    end
  end

  assign an_n  = an_n_q;
  assign seg_n = seg_n_q;

endmodule

// File: tb/tb_stopwatch_display_driver.sv
// Directed self-checking bench for stopwatch_display_driver (REFRESH_DIV=4, BLINK_DIV=2).
// Samples outputs on the falling edge; inputs are driven just after a falling edge.
module tb_stopwatch_display_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] minutes = 8'd0;
  logic [5:0] seconds = 6'd0;
  logic [1:0] status = 2'b00;
  logic [3:0] an_n;
  logic [6:0] seg_n;
  logic       busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stopwatch_display_driver #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (2)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .minutes (minutes),
    .seconds (seconds),
    .status  (status),
    .an_n    (an_n),
    .seg_n   (seg_n),
    .busy    (busy)
  );

  // Watches 16 samples (one full frame) and records each digit's pattern.
  // f[0]=sec ones .. f[3]=min tens; seen = digit slots observed; bad = samples not one-cold.
  task automatic capture_frame(output logic [3:0][6:0] f, output logic [3:0] seen, output int bad);
    f    = '1;
    seen = '0;
    bad  = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an_n)
        4'hE: begin f[0] = seg_n; seen[0] = 1'b1; end
        4'hD: begin f[1] = seg_n; seen[1] = 1'b1; end
        4'hB: begin f[2] = seg_n; seen[2] = 1'b1; end
        4'h7: begin f[3] = seg_n; seen[3] = 1'b1; end
        default: bad++;
      endcase
    end
  endtask

  // Waits for a conversion to start and finish; ok=0 if either bound expires.
  task automatic wait_conv(output bit ok);
    int n;
    ok = 1'b0;
    n  = 0;
    while (busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (busy !== 1'b1) return;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin @(negedge clk); n++; end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    logic [3:0][6:0] f;
    logic [3:0] seen;
    int bad;
    bit ok;
    bit busy_seen;
    rst_n = 1'b0; minutes = 8'd0; seconds = 6'd0; status = 2'b00;
    repeat (3) @(negedge clk);
    tests++; if (an_n !== 4'hF)  begin fails++; $display("FAIL reset_an_n got %h want f", an_n); end
    tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL reset_seg_n got %h want 7f", seg_n); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (busy === 1'b1) busy_seen = 1'b1; end
    tests++; if (!busy_seen) begin fails++; $display("FAIL reset_busy_after_release got 0 want 1 within 2 cycles"); end
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b0) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    tests++; if (!ok) begin fails++; $display("FAIL reset_conv_done got busy=%b want 0 within 20 cycles", busy); end
    capture_frame(f, seen, bad);
    tests++; if (seen !== 4'hF || bad != 0) begin fails++; $display("FAIL reset_scan seen=%h bad=%0d want seen=f bad=0", seen, bad); end
    tests++; if (f !== {7'h40, 7'h40, 7'h40, 7'h40}) begin fails++; $display("FAIL reset_zero_digits got %h want all 40", f); end
  endtask

  task automatic test_convert;
    logic [3:0] exp_an [4];
    logic [6:0] exp_seg [4];
    logic [3:0] prev;
    int cnt;
    bit started;
    bit synced;
    exp_an  = '{4'hE, 4'hD, 4'hB, 4'h7};
    exp_seg = '{7'h19, 7'h30, 7'h24, 7'h79};
    @(negedge clk);
    minutes = 8'd12; seconds = 6'd34;
    cnt = 0; started = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy === 1'b1) begin started = 1'b1; cnt++; end
      else if (started) break;
    end
    tests++; if (cnt != 10) begin fails++; $display("FAIL convert_latency got %0d busy cycles want 10", cnt); end
    prev = an_n; synced = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (prev == 4'h7 && an_n == 4'hE) begin synced = 1'b1; break; end
      prev = an_n;
    end
    tests++; if (!synced) begin fails++; $display("FAIL convert_scan_sync got no 7->E transition within 40 cycles"); end
    for (int k = 0; k < 16; k++) begin
      if (k > 0) @(negedge clk);
      tests++;
      if (an_n !== exp_an[k/4]) begin fails++; $display("FAIL convert_an_n[%0d] got %h want %h", k, an_n, exp_an[k/4]); end
      tests++;
      if (seg_n !== exp_seg[k/4]) begin fails++; $display("FAIL convert_seg_n[%0d] got %h want %h", k, seg_n, exp_seg[k/4]); end
    end
  endtask

  task automatic test_saturation;
    logic [3:0][6:0] f;
    logic [3:0] seen;
    int bad;
    bit ok;
    @(negedge clk); minutes = 8'd150; seconds = 6'd59;
    wait_conv(ok);
    tests++; if (!ok) begin fails++; $display("FAIL sat150_conv got timeout want conversion"); end
    capture_frame(f, seen, bad);
    tests++; if (f !== {7'h10, 7'h10, 7'h12, 7'h10}) begin fails++; $display("FAIL sat150_display got %h want 99:59", f); end
    @(negedge clk); minutes = 8'd255; seconds = 6'd0;
    wait_conv(ok);
    tests++; if (!ok) begin fails++; $display("FAIL sat255_conv got timeout want conversion"); end
    capture_frame(f, seen, bad);
    tests++; if (f !== {7'h10, 7'h10, 7'h40, 7'h40}) begin fails++; $display("FAIL sat255_display got %h want 99:00", f); end
    @(negedge clk); minutes = 8'd5; seconds = 6'd63;
    wait_conv(ok);
    tests++; if (!ok) begin fails++; $display("FAIL sec63_conv got timeout want conversion"); end
    capture_frame(f, seen, bad);
    tests++; if (f !== {7'h40, 7'h12, 7'h02, 7'h30}) begin fails++; $display("FAIL sec63_display got %h want 05:63", f); end
  endtask

  task automatic test_back_to_back;
    logic       b_hist [30];
    logic [3:0] a_hist [30];
    logic [6:0] s_hist [30];
    logic [3:0][6:0] f;
    logic [3:0] seen;
    int bad, run1, gap, run2, pos, mix;
    logic [6:0] want;
    @(negedge clk); minutes = 8'd0; seconds = 6'd10;
    pos = 0;
    while (busy !== 1'b1 && pos < 20) begin @(negedge clk); pos++; end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_start got busy=%b want 1", busy); end
    for (int i = 0; i < 30; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 3) seconds = 6'd11;
      b_hist[i] = busy; a_hist[i] = an_n; s_hist[i] = seg_n;
    end
    pos = 0; run1 = 0; gap = 0; run2 = 0;
    while (pos < 30 && b_hist[pos] === 1'b1) begin run1++; pos++; end
    while (pos < 30 && b_hist[pos] === 1'b0) begin gap++;  pos++; end
    while (pos < 30 && b_hist[pos] === 1'b1) begin run2++; pos++; end
    tests++; if (run1 != 10) begin fails++; $display("FAIL b2b_first_conv got %0d busy cycles want 10", run1); end
    tests++; if (gap != 1)   begin fails++; $display("FAIL b2b_idle_gap got %0d idle cycles want 1", gap); end
    tests++; if (run2 != 10) begin fails++; $display("FAIL b2b_second_conv got %0d busy cycles want 10", run2); end
    // Between the two loads the display must show exactly 00:10.
    mix = 0;
    for (int i = 11; i <= 21; i++) begin
      case (a_hist[i])
        4'hE:    want = 7'h40;
        4'hD:    want = 7'h79;
        default: want = 7'h40;
      endcase
      if (s_hist[i] !== want) mix++;
    end
    tests++; if (mix != 0) begin fails++; $display("FAIL b2b_intermediate got %0d wrong samples want 0 (00:10)", mix); end
    capture_frame(f, seen, bad);
    tests++; if (f !== {7'h40, 7'h40, 7'h79, 7'h79}) begin fails++; $display("FAIL b2b_final got %h want 00:11", f); end
  endtask

  task automatic test_blink;
    int n, blanks;
    @(negedge clk); status = 2'b10;
`ifdef STOPWATCH_DISP_BLINK_EN
    n = 0;
    while (an_n !== 4'hF && n < 100) begin @(negedge clk); n++; end
    tests++; if (an_n !== 4'hF) begin fails++; $display("FAIL blink_blank_start got %h want f", an_n); end
    n = 0;
    while (an_n === 4'hF && n < 100) begin @(negedge clk); n++; end
    tests++; if (n != 32) begin fails++; $display("FAIL blink_blank_len got %0d cycles want 32", n); end
    n = 0;
    while (an_n !== 4'hF && n < 100) begin @(negedge clk); n++; end
    tests++; if (n != 32) begin fails++; $display("FAIL blink_lit_len got %0d cycles want 32", n); end
    repeat (5) @(negedge clk);
    tests++; if (an_n !== 4'hF) begin fails++; $display("FAIL blink_mid_blank got %h want f", an_n); end
    status = 2'b01;
    @(negedge clk);
    tests++; if (an_n === 4'hF) begin fails++; $display("FAIL blink_resume got %h want lit", an_n); end
`else
    blanks = 0;
    for (int i = 0; i < 80; i++) begin @(negedge clk); if (an_n === 4'hF) blanks++; end
    tests++; if (blanks != 0) begin fails++; $display("FAIL paused_lit got %0d blank cycles want 0", blanks); end
    status = 2'b01;
    @(negedge clk);
    tests++; if (an_n === 4'hF) begin fails++; $display("FAIL running_lit got %h want lit", an_n); end
`endif
    status = 2'b00;
  endtask

  task automatic test_async_reset;
    logic [3:0][6:0] f;
    logic [3:0] seen;
    int bad;
    logic [6:0] want;
    @(negedge clk); minutes = 8'd7; seconds = 6'd42;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (an_n !== 4'hF)  begin fails++; $display("FAIL async_an_n got %h want f", an_n); end
    tests++; if (seg_n !== 7'h7F) begin fails++; $display("FAIL async_seg_n got %h want 7f", seg_n); end
    tests++; if (busy !== 1'b0)  begin fails++; $display("FAIL async_busy got %b want 0", busy); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    tests++; if (an_n !== 4'hE) begin fails++; $display("FAIL async_scan_restart got %h want e", an_n); end
    repeat (11) @(negedge clk);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_reconv_busy got %b want 0 after 12 cycles", busy); end
    case (an_n)
      4'hE:    want = 7'h24;
      4'hD:    want = 7'h19;
      4'hB:    want = 7'h78;
      default: want = 7'h40;
    endcase
    tests++; if (seg_n !== want) begin fails++; $display("FAIL async_reconv_seg got %h want %h (an_n=%h)", seg_n, want, an_n); end
    capture_frame(f, seen, bad);
    tests++; if (f !== {7'h40, 7'h78, 7'h19, 7'h24}) begin fails++; $display("FAIL async_reconv_frame got %h want 07:42", f); end
  endtask

  initial begin
    test_reset();
    test_convert();
    test_saturation();
    test_back_to_back();
    test_blink();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
